// File: rtl/shiftregister_pkg.sv
// Shared definitions for the shift register sequencer and the shift register benches.
package shiftregister_pkg;

    // Default shift register width, also the number of shifts per command.
    localparam int DEFAULT_WIDTH = 4;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage : shiftregister_pkg

// File: rtl/shift_counter.sv
// Saturating shift counter: counts completed shifts, clears synchronously and
// flags the enabled cycle that performs the last (WIDTH-th) shift.
module shift_counter
    import shiftregister_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic             full_s;

    assign full_s = (count_r == TERM_C);
    // The shift performed this cycle is the last one when the count is one short of WIDTH.
    assign last   = en && (count_r == (TERM_C - ONE_C));
    assign count  = count_r;

    // Count enabled cycles, saturating at WIDTH so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && !full_s) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

endmodule : shift_counter

// File: rtl/shift_register_sequencer.sv
// Sequences a right-shift register: one preset load strobe followed by exactly
// WIDTH shift strobes, with serial fill from a captured constant or LSB feedback.
module shift_register_sequencer
    import shiftregister_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clockpulse,
    input  logic             notclear,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] presetData,
    input  logic             fillBit,
    input  logic             rotate,
    input  logic             registerLsb,
    output logic             ready,
    output logic             enablePreset,
    output logic [WIDTH-1:0] preset,
    output logic             shiftEnable,
    output logic             serialInput,
    output logic             serialOut,
    output logic             done,
    output logic [CNT_W-1:0] shiftCount
);

    seq_state_e       state_r;
    logic             ready_r;
    logic             enable_preset_r;
    logic             shift_enable_r;
    logic             done_r;
    logic [WIDTH-1:0] preset_r;
    logic             fill_r;
    logic             rotate_r;

    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             cnt_last_s;
    logic [CNT_W-1:0] cnt_s;

    // Counter is cleared when a command loads and when a running command is aborted.
    assign cnt_clr_s = (state_r == LOAD) || (abort && (state_r != IDLE));
    assign cnt_en_s  = shift_enable_r && !abort;

    shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_counter (
        .clk   (clockpulse),
        .rst_n (notclear),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s),
        .last  (cnt_last_s)
    );

    // Command FSM with registered Moore strobes and command capture registers.
    always_ff @(posedge clockpulse or negedge notclear) begin
        if (!notclear) begin
            state_r         <= IDLE;
            ready_r         <= 1'b1;
            enable_preset_r <= 1'b0;
            shift_enable_r  <= 1'b0;
            done_r          <= 1'b0;
            preset_r        <= {WIDTH{1'b0}};
            fill_r          <= 1'b0;
            rotate_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Abort takes priority over a simultaneous start.
                    if (start && !abort) begin
                        state_r         <= LOAD;
                        ready_r         <= 1'b0;
                        enable_preset_r <= 1'b1;
                        preset_r        <= presetData;
                        fill_r          <= fillBit;
                        rotate_r        <= rotate;
                    end else begin
                        state_r         <= IDLE;
                        ready_r         <= 1'b1;
                        enable_preset_r <= 1'b0;
                    end
                    shift_enable_r <= 1'b0;
                    done_r         <= 1'b0;
                end
                LOAD: begin
                    enable_preset_r <= 1'b0;
                    done_r          <= 1'b0;
                    if (abort) begin
                        state_r        <= IDLE;
                        ready_r        <= 1'b1;
                        shift_enable_r <= 1'b0;
                    end else begin
                        state_r        <= SHIFT;
                        ready_r        <= 1'b0;
                        shift_enable_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    enable_preset_r <= 1'b0;
                    if (abort) begin
                        state_r        <= IDLE;
                        ready_r        <= 1'b1;
                        shift_enable_r <= 1'b0;
                        done_r         <= 1'b0;
                    end else if (cnt_last_s) begin
                        state_r        <= DONE;
                        ready_r        <= 1'b0;
                        shift_enable_r <= 1'b0;
                        done_r         <= 1'b1;
                    end else begin
                        state_r        <= SHIFT;
                        ready_r        <= 1'b0;
                        shift_enable_r <= 1'b1;
                        done_r         <= 1'b0;
                    end
                end
                DONE: begin
                    // A start seen here is dropped; the source must reissue it from IDLE.
                    state_r         <= IDLE;
                    ready_r         <= 1'b1;
                    enable_preset_r <= 1'b0;
                    shift_enable_r  <= 1'b0;
                    done_r          <= 1'b0;
                end
                default: begin
                    state_r         <= IDLE;
                    ready_r         <= 1'b1;
                    enable_preset_r <= 1'b0;
                    shift_enable_r  <= 1'b0;
                    done_r          <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_r;
    assign enablePreset = enable_preset_r;
    assign shiftEnable  = shift_enable_r;
    assign done         = done_r;
    // Preset is held after the command so a re-pulsed load reproduces the same word.
    assign preset       = preset_r;
    assign shiftCount   = cnt_s;
    assign serialInput  = rotate_r ? registerLsb : fill_r;
    assign serialOut    = registerLsb & shift_enable_r;

endmodule : shift_register_sequencer

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer paired with a behavioural 4-bit right-shift register.
module tb_shift_register_sequencer;

    logic       clockpulse = 1'b0;
    logic       notclear;
    logic       start;
    logic       abort;
    logic [3:0] presetData;
    logic       fillBit;
    logic       rotate;
    logic       registerLsb;
    logic       ready;
    logic       enablePreset;
    logic [3:0] preset;
    logic       shiftEnable;
    logic       serialInput;
    logic       serialOut;
    logic       done;
    logic [2:0] shiftCount;

    logic [3:0] sreg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle observations of one command, bit j = cycle j after the start-sampling edge.
    logic [12:0] ep_v, se_v, dn_v, rdy_v, so_v, si_v;
    logic [2:0]  cnt_a [0:12];

    shift_register_sequencer #(.WIDTH(4)) dut (
        .clockpulse   (clockpulse),
        .notclear     (notclear),
        .start        (start),
        .abort        (abort),
        .presetData   (presetData),
        .fillBit      (fillBit),
        .rotate       (rotate),
        .registerLsb  (registerLsb),
        .ready        (ready),
        .enablePreset (enablePreset),
        .preset       (preset),
        .shiftEnable  (shiftEnable),
        .serialInput  (serialInput),
        .serialOut    (serialOut),
        .done         (done),
        .shiftCount   (shiftCount)
    );

    always #5 clockpulse = ~clockpulse;

    // The shift register being sequenced.
    always_ff @(posedge clockpulse or negedge notclear) begin
        if (!notclear)         sreg <= 4'b0000;
        else if (enablePreset) sreg <= preset;
        else if (shiftEnable)  sreg <= {serialInput, sreg[3:1]};
    end
    assign registerLsb = sreg[0];

    // Issue one command and record 12 cycles of outputs; optional re-starts and abort cycles.
    task automatic run_cmd(input logic [3:0] pd, input logic fb, input logic rot,
                           input int re_a, input int re_b, input int ab_at);
        @(negedge clockpulse);
        presetData = pd; fillBit = fb; rotate = rot; start = 1'b1; abort = 1'b0;
        ep_v = '0; se_v = '0; dn_v = '0; rdy_v = '0; so_v = '0; si_v = '0;
        cnt_a[0] = 3'd0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clockpulse);
            ep_v[j] = enablePreset; se_v[j] = shiftEnable; dn_v[j] = done;
            rdy_v[j] = ready; so_v[j] = serialOut; si_v[j] = serialInput;
            cnt_a[j] = shiftCount;
            start = (j == re_a) || (j == re_b);
            if (start) begin
                presetData = ~pd; fillBit = ~fb; rotate = ~rot;
            end
            abort = (j == ab_at);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        notclear = 1'b0; start = 1'b0; abort = 1'b0;
        presetData = 4'b0000; fillBit = 1'b0; rotate = 1'b0;
        repeat (2) @(negedge clockpulse);
        n_cmp++;
        if ({ready, enablePreset, shiftEnable, done, serialInput, serialOut, shiftCount, preset} !== 13'b1_0000_0000_0000) begin
            n_fail++;
            $display("FAIL reset_hold act=%b exp=%b", {ready, enablePreset, shiftEnable, done, serialInput, serialOut, shiftCount, preset}, 13'b1_0000_0000_0000);
        end
        notclear = 1'b1;
        repeat (2) @(negedge clockpulse);
        n_cmp++;
        if ({ready, enablePreset, shiftEnable, done, shiftCount, preset} !== 11'b100_0000_0000) begin
            n_fail++;
            $display("FAIL reset_idle act=%b exp=%b", {ready, enablePreset, shiftEnable, done, shiftCount, preset}, 11'b100_0000_0000);
        end
    endtask

    task automatic test_basic();
        run_cmd(4'b0011, 1'b0, 1'b0, 0, 0, 0);
        n_cmp++; if (ep_v !== 13'h0002) begin n_fail++; $display("FAIL basic_preset_strobe act=%b exp=%b", ep_v, 13'h0002); end
        n_cmp++; if (se_v !== 13'h003C) begin n_fail++; $display("FAIL basic_shift_strobe act=%b exp=%b", se_v, 13'h003C); end
        n_cmp++; if (dn_v !== 13'h0040) begin n_fail++; $display("FAIL basic_done act=%b exp=%b", dn_v, 13'h0040); end
        n_cmp++; if (rdy_v !== 13'h1F80) begin n_fail++; $display("FAIL basic_ready act=%b exp=%b", rdy_v, 13'h1F80); end
        n_cmp++; if (so_v !== 13'h000C) begin n_fail++; $display("FAIL basic_serial_out act=%b exp=%b", so_v, 13'h000C); end
        n_cmp++; if (si_v !== 13'h0000) begin n_fail++; $display("FAIL basic_serial_in act=%b exp=%b", si_v, 13'h0000); end
        n_cmp++; if (sreg !== 4'b0000) begin n_fail++; $display("FAIL basic_reg act=%b exp=%b", sreg, 4'b0000); end
        n_cmp++; if (cnt_a[6] !== 3'd4) begin n_fail++; $display("FAIL basic_count act=%0d exp=%0d", cnt_a[6], 4); end
        n_cmp++; if ((ep_v & se_v) !== 13'h0000) begin n_fail++; $display("FAIL basic_strobe_overlap act=%b exp=%b", ep_v & se_v, 13'h0000); end
        n_cmp++; if (preset !== 4'b0011) begin n_fail++; $display("FAIL basic_preset_held act=%b exp=%b", preset, 4'b0011); end
    endtask

    task automatic test_rotate();
        run_cmd(4'b0011, 1'b0, 1'b1, 0, 0, 0);
        n_cmp++; if (dn_v !== 13'h0040) begin n_fail++; $display("FAIL rotate_done act=%b exp=%b", dn_v, 13'h0040); end
        n_cmp++; if ((si_v & se_v) !== so_v) begin n_fail++; $display("FAIL rotate_feedback act=%b exp=%b", si_v & se_v, so_v); end
        n_cmp++; if (so_v !== 13'h000C) begin n_fail++; $display("FAIL rotate_serial_out act=%b exp=%b", so_v, 13'h000C); end
        n_cmp++; if (sreg !== 4'b0011) begin n_fail++; $display("FAIL rotate_reg act=%b exp=%b", sreg, 4'b0011); end
    endtask

    task automatic test_fill();
        run_cmd(4'b0000, 1'b1, 1'b0, 0, 0, 0);
        n_cmp++; if (sreg !== 4'b1111) begin n_fail++; $display("FAIL fill_reg act=%b exp=%b", sreg, 4'b1111); end
        n_cmp++; if (cnt_a[12] !== 3'd4) begin n_fail++; $display("FAIL fill_count act=%0d exp=%0d", cnt_a[12], 4); end
        n_cmp++; if (si_v !== 13'h1FFE) begin n_fail++; $display("FAIL fill_serial_in act=%b exp=%b", si_v, 13'h1FFE); end
    endtask

    task automatic test_start_ignored();
        run_cmd(4'b1010, 1'b0, 1'b0, 3, 6, 0);
        n_cmp++; if (dn_v !== 13'h0040) begin n_fail++; $display("FAIL ignored_done act=%b exp=%b", dn_v, 13'h0040); end
        n_cmp++; if (ep_v !== 13'h0002) begin n_fail++; $display("FAIL ignored_preset_strobe act=%b exp=%b", ep_v, 13'h0002); end
        n_cmp++; if (rdy_v !== 13'h1F80) begin n_fail++; $display("FAIL ignored_ready act=%b exp=%b", rdy_v, 13'h1F80); end
        n_cmp++; if (preset !== 4'b1010) begin n_fail++; $display("FAIL ignored_preset act=%b exp=%b", preset, 4'b1010); end
        n_cmp++; if (sreg !== 4'b0000) begin n_fail++; $display("FAIL ignored_reg act=%b exp=%b", sreg, 4'b0000); end
    endtask

    task automatic test_abort();
        run_cmd(4'b0110, 1'b1, 1'b0, 0, 0, 3);
        n_cmp++; if (se_v !== 13'h000C) begin n_fail++; $display("FAIL abort_shift_strobe act=%b exp=%b", se_v, 13'h000C); end
        n_cmp++; if (dn_v !== 13'h0000) begin n_fail++; $display("FAIL abort_no_done act=%b exp=%b", dn_v, 13'h0000); end
        n_cmp++; if (rdy_v !== 13'h1FF0) begin n_fail++; $display("FAIL abort_ready act=%b exp=%b", rdy_v, 13'h1FF0); end
        n_cmp++; if (cnt_a[4] !== 3'd0) begin n_fail++; $display("FAIL abort_count act=%0d exp=%0d", cnt_a[4], 0); end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clockpulse);
        start = 1'b1; abort = 1'b1; presetData = 4'b1111;
        @(negedge clockpulse);
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if ({ready, enablePreset} !== 2'b10) begin
            n_fail++; $display("FAIL abort_wins_idle act=%b exp=%b", {ready, enablePreset}, 2'b10);
        end
    endtask

    task automatic test_midreset();
        @(negedge clockpulse);
        presetData = 4'b0101; fillBit = 1'b1; rotate = 1'b0; start = 1'b1;
        @(negedge clockpulse);
        start = 1'b0;
        repeat (2) @(posedge clockpulse);
        #2 notclear = 1'b0;
        #1;
        n_cmp++;
        if ({ready, enablePreset, shiftEnable, done, shiftCount, preset} !== 11'b100_0000_0000) begin
            n_fail++;
            $display("FAIL midreset_outputs act=%b exp=%b", {ready, enablePreset, shiftEnable, done, shiftCount, preset}, 11'b100_0000_0000);
        end
        @(negedge clockpulse);
        notclear = 1'b1;
        run_cmd(4'b1001, 1'b0, 1'b1, 0, 0, 0);
        n_cmp++; if (se_v !== 13'h003C) begin n_fail++; $display("FAIL midreset_shifts act=%b exp=%b", se_v, 13'h003C); end
        n_cmp++; if (dn_v !== 13'h0040) begin n_fail++; $display("FAIL midreset_done act=%b exp=%b", dn_v, 13'h0040); end
        n_cmp++; if (sreg !== 4'b1001) begin n_fail++; $display("FAIL midreset_reg act=%b exp=%b", sreg, 4'b1001); end
    endtask

    task automatic test_random();
        logic [3:0]  pd;
        logic        fb, rot;
        logic [3:0]  exp_reg;
        logic [12:0] exp_so;
        for (int i = 0; i < 8; i++) begin
            pd  = 4'($urandom_range(15, 0));
            fb  = 1'($urandom_range(1, 0));
            rot = 1'($urandom_range(1, 0));
            // k-th shift exposes original bit k; after WIDTH shifts the word is rotated home or all fill.
            exp_so  = {7'b0000000, pd, 2'b00};
            exp_reg = rot ? pd : {4{fb}};
            run_cmd(pd, fb, rot, 0, 0, 0);
            n_cmp++; if (dn_v !== 13'h0040) begin n_fail++; $display("FAIL rand%0d_done act=%b exp=%b", i, dn_v, 13'h0040); end
            n_cmp++; if (so_v !== exp_so) begin n_fail++; $display("FAIL rand%0d_serial_out act=%b exp=%b", i, so_v, exp_so); end
            n_cmp++; if (sreg !== exp_reg) begin n_fail++; $display("FAIL rand%0d_reg act=%b exp=%b", i, sreg, exp_reg); end
            n_cmp++; if (preset !== pd) begin n_fail++; $display("FAIL rand%0d_preset act=%b exp=%b", i, preset, pd); end
            n_cmp++; if (cnt_a[6] !== 3'd4) begin n_fail++; $display("FAIL rand%0d_count act=%0d exp=%0d", i, cnt_a[6], 4); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotate();
        test_fill();
        test_start_ignored();
        test_abort();
        test_abort_start_idle();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_shift_register_sequencer
